// File: rtl/orion_rom_arb_pkg.sv
// ============================================================================
//  Module   : orion_rom_arb_pkg
//  Brief    : Shared types and round-robin helper for the Orion ROM arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package orion_rom_arb_pkg;

    localparam int NUM_RQ = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RQ_ROM1 = 2'd0,
        RQ_ROM2 = 2'd1,
        RQ_DSK  = 2'd2
    } rq_e;

    // Successor of a requester index, modulo NUM_RQ.
    function automatic rq_e rr_next(input rq_e cur);
        rq_e nxt;
        case (cur)
            RQ_ROM1: nxt = RQ_ROM2;
            RQ_ROM2: nxt = RQ_DSK;
            default: nxt = RQ_ROM1;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/orion_rr_arbiter3.sv
// ============================================================================
//  Module   : orion_rr_arbiter3
//  Brief    : Combinational 3-way round-robin picker, search starts at last+1.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module orion_rr_arbiter3
    import orion_rom_arb_pkg::*;
(
    input  logic [NUM_RQ-1:0] req,
    input  rq_e               last,
    output logic              valid,
    output rq_e               winner
);

    rq_e cand;

    always_comb begin
        valid  = 1'b0;
        winner = RQ_ROM1;
        cand   = rr_next(last);
        for (int i = 0; i < NUM_RQ; i++) begin
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
            cand = rr_next(cand);
        end
    end

endmodule

`default_nettype wire

// File: rtl/orion_rom_arbiter.sv
// ============================================================================
//  Module   : orion_rom_arbiter
//  Brief    : Shares one byte-wide read memory between ROM1, ROM2 and ROM-disk.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module orion_rom_arbiter
    import orion_rom_arb_pkg::*;
#(
    parameter int                MEM_AW    = 22,
    parameter logic [MEM_AW-1:0] ROM1_BASE = 22'h000000,
    parameter logic [MEM_AW-1:0] ROM2_BASE = 22'h100000,
    parameter logic [MEM_AW-1:0] DSK_BASE  = 22'h200000,
    parameter int                TIMEOUT   = 1023
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_rom1_req,
    input  logic [12:0]       i_rom1_addr,
    output logic [7:0]        o_rom1_rdata,
    output logic              o_rom1_ack,
    input  logic              i_rom2_req,
    input  logic [19:0]       i_rom2_addr,
    output logic [7:0]        o_rom2_rdata,
    output logic              o_rom2_ack,
    input  logic              i_dsk_req,
    input  logic [19:0]       i_dsk_addr,
    output logic [7:0]        o_dsk_rdata,
    output logic              o_dsk_ack,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_timeout
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e            state;
    state_e            state_nxt;
    rq_e               winner;
    rq_e               last;
    rq_e               pick_idx;
    logic              pick_valid;
    logic [MEM_AW-1:0] pick_addr;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_req;
    logic [CNT_W-1:0]  cnt;
    logic              to_flag;
    logic [7:0]        rom1_rdata;
    logic [7:0]        rom2_rdata;
    logic [7:0]        dsk_rdata;
    logic              busy;
    logic              complete;
    logic              expire;
    logic              timeout_hit;
    logic              rd_we;
    logic [7:0]        rd_val;

    orion_rr_arbiter3 u_rr (
        .req    ({i_dsk_req, i_rom2_req, i_rom1_req}),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // Physical address wraps modulo 2^MEM_AW by construction of the adder width.
    always_comb begin
        case (pick_idx)
            RQ_ROM1: pick_addr = ROM1_BASE + MEM_AW'(i_rom1_addr);
            RQ_ROM2: pick_addr = ROM2_BASE + MEM_AW'(i_rom2_addr);
            default: pick_addr = DSK_BASE  + MEM_AW'(i_dsk_addr);
        endcase
    end

    always_comb begin
        busy        = (state == ISSUE) || (state == WAIT);
        complete    = ((state == ISSUE) && i_mem_gnt && i_mem_rvalid) ||
                      ((state == WAIT)  && i_mem_rvalid);
        expire      = busy && (cnt == CNT_W'(TIMEOUT - 1));
        timeout_hit = expire && !complete;
        rd_we       = complete || timeout_hit;
        rd_val      = complete ? i_mem_rdata : 8'hFF;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE: begin
                if (complete || timeout_hit) state_nxt = RESP;
                else if (i_mem_gnt)          state_nxt = WAIT;
            end
            WAIT:    if (complete || timeout_hit) state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            winner     <= RQ_ROM1;
            last       <= RQ_DSK;
            mem_addr   <= '0;
            mem_req    <= 1'b0;
            cnt        <= '0;
            to_flag    <= 1'b0;
            rom1_rdata <= 8'h00;
            rom2_rdata <= 8'h00;
            dsk_rdata  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner   <= pick_idx;
                        mem_addr <= pick_addr;
                        mem_req  <= 1'b1;
                        cnt      <= '0;
                        to_flag  <= 1'b0;
                    end
                end
                ISSUE, WAIT: begin
                    if (!expire)                           cnt     <= cnt + CNT_W'(1);
                    if (i_mem_gnt || rd_we)                mem_req <= 1'b0;
                    if (timeout_hit)                       to_flag <= 1'b1;
                    if (rd_we && (winner == RQ_ROM1))      rom1_rdata <= rd_val;
                    if (rd_we && (winner == RQ_ROM2))      rom2_rdata <= rd_val;
                    if (rd_we && (winner == RQ_DSK))       dsk_rdata  <= rd_val;
                end
                default: last <= winner;
            endcase
        end
    end

    assign o_mem_req    = mem_req;
    assign o_mem_addr   = mem_addr;
    assign o_rom1_rdata = rom1_rdata;
    assign o_rom2_rdata = rom2_rdata;
    assign o_dsk_rdata  = dsk_rdata;
    assign o_rom1_ack   = (state == RESP) && (winner == RQ_ROM1);
    assign o_rom2_ack   = (state == RESP) && (winner == RQ_ROM2);
    assign o_dsk_ack    = (state == RESP) && (winner == RQ_DSK);
    assign o_timeout    = (state == RESP) && to_flag;

endmodule

`default_nettype wire

// File: tb/tb_orion_rom_arbiter.sv
// ============================================================================
//  Module   : tb_orion_rom_arbiter
//  Brief    : Directed bench; instance a uses defaults, b uses TIMEOUT=16 and a
//             high DSK_BASE so the disk region wraps. Both share stimulus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_orion_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rom1_req, rom2_req, dsk_req;
    logic [12:0] rom1_addr;
    logic [19:0] rom2_addr, dsk_addr;
    logic        mem_gnt, mem_rvalid;
    logic [7:0]  mem_rdata;

    logic [7:0]  rom1_rdata_a, rom2_rdata_a, dsk_rdata_a;
    logic        rom1_ack_a, rom2_ack_a, dsk_ack_a, mem_req_a, timeout_a;
    logic [21:0] mem_addr_a;
    logic [7:0]  rom1_rdata_b, rom2_rdata_b, dsk_rdata_b;
    logic        rom1_ack_b, rom2_ack_b, dsk_ack_b, mem_req_b, timeout_b;
    logic [21:0] mem_addr_b;

    wire  [2:0]  acks_a = {dsk_ack_a, rom2_ack_a, rom1_ack_a};
    wire  [2:0]  acks_b = {dsk_ack_b, rom2_ack_b, rom1_ack_b};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int c0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    orion_rom_arbiter dut_a (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_rom1_req(rom1_req), .i_rom1_addr(rom1_addr), .o_rom1_rdata(rom1_rdata_a), .o_rom1_ack(rom1_ack_a),
        .i_rom2_req(rom2_req), .i_rom2_addr(rom2_addr), .o_rom2_rdata(rom2_rdata_a), .o_rom2_ack(rom2_ack_a),
        .i_dsk_req(dsk_req),   .i_dsk_addr(dsk_addr),   .o_dsk_rdata(dsk_rdata_a),   .o_dsk_ack(dsk_ack_a),
        .o_mem_req(mem_req_a), .o_mem_addr(mem_addr_a), .i_mem_gnt(mem_gnt),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_timeout(timeout_a)
    );

    orion_rom_arbiter #(.TIMEOUT(16), .DSK_BASE(22'h380000)) dut_b (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_rom1_req(rom1_req), .i_rom1_addr(rom1_addr), .o_rom1_rdata(rom1_rdata_b), .o_rom1_ack(rom1_ack_b),
        .i_rom2_req(rom2_req), .i_rom2_addr(rom2_addr), .o_rom2_rdata(rom2_rdata_b), .o_rom2_ack(rom2_ack_b),
        .i_dsk_req(dsk_req),   .i_dsk_addr(dsk_addr),   .o_dsk_rdata(dsk_rdata_b),   .o_dsk_ack(dsk_ack_b),
        .o_mem_req(mem_req_b), .o_mem_addr(mem_addr_b), .i_mem_gnt(mem_gnt),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_timeout(timeout_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n    = 1'b0;
        rom1_req   = 1'b0;
        rom2_req   = 1'b0;
        dsk_req    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        step;
        step;
        reset_n = 1'b1;
    endtask

    // Memory side of one read on instance a; returns in the RESP cycle.
    task automatic transact(input string tag, input logic [21:0] exp_addr,
                            input logic [7:0] data, input int gdly);
        int n = 0;
        while (!mem_req_a && n < 20) begin
            step;
            n++;
        end
        check({tag, "_req"}, 32'(mem_req_a), 32'd1);
        check({tag, "_addr"}, 32'(mem_addr_a), 32'(exp_addr));
        for (int i = 0; i < gdly; i++) begin
            step;
            check({tag, "_hold_req"}, 32'(mem_req_a), 32'd1);
            check({tag, "_hold_addr"}, 32'(mem_addr_a), 32'(exp_addr));
        end
        mem_gnt = 1'b1;
        step;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rom1_addr = '0;
        rom2_addr = '0;
        dsk_addr  = '0;
        mem_rdata = '0;
        do_reset;

        check("rst_mem_req", 32'(mem_req_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_acks", 32'(acks_a), 32'd0);
        check("rst_rdata", {8'h0, rom1_rdata_a, rom2_rdata_a, dsk_rdata_a}, 32'd0);
        check("rst_timeout", 32'(timeout_a), 32'd0);

        // Basic ROM1 read, latency 4
        rom1_addr = 13'h0123;
        rom1_req  = 1'b1;
        c0 = cyc;
        transact("t1", 22'h000123, 8'hA5, 1);
        check("t1_latency", 32'(cyc - c0), 32'd4);
        check("t1_ack", 32'(acks_a), 32'b001);
        check("t1_rdata", 32'(rom1_rdata_a), 32'hA5);
        check("t1_timeout", 32'(timeout_a), 32'd0);
        rom1_req = 1'b0;
        step;
        check("t1_ack_pulse", 32'(acks_a), 32'd0);
        step;
        step;
        check("t1_rdata_held", 32'(rom1_rdata_a), 32'hA5);

        // Round-robin order
        do_reset;
        rom1_addr = 13'h1FFF;
        rom2_addr = 20'h12345;
        dsk_addr  = 20'hABCDE;
        rom1_req  = 1'b1;
        rom2_req  = 1'b1;
        dsk_req   = 1'b1;
        transact("rr1", 22'h001FFF, 8'h11, 0);
        check("rr1_ack", 32'(acks_a), 32'b001);
        check("rr1_rdata", 32'(rom1_rdata_a), 32'h11);
        rom1_req = 1'b0;
        step;
        rom1_req = 1'b1;
        transact("rr2", 22'h112345, 8'h22, 0);
        check("rr2_ack", 32'(acks_a), 32'b010);
        check("rr2_rdata", 32'(rom2_rdata_a), 32'h22);
        rom2_req = 1'b0;
        transact("rr3", 22'h2ABCDE, 8'h33, 0);
        check("rr3_ack", 32'(acks_a), 32'b100);
        check("rr3_rdata", 32'(dsk_rdata_a), 32'h33);
        dsk_req = 1'b0;
        transact("rr4", 22'h001FFF, 8'h44, 0);
        check("rr4_ack", 32'(acks_a), 32'b001);
        check("rr4_rdata", 32'(rom1_rdata_a), 32'h44);
        check("rr_other_rdata", {16'h0, rom2_rdata_a, dsk_rdata_a}, 32'h2233);
        rom1_req = 1'b0;

        // Timeout on instance b (TIMEOUT=16): gnt given, rvalid never comes
        do_reset;
        rom2_addr = 20'h00042;
        rom2_req  = 1'b1;
        step;
        check("to_issue", 32'(mem_req_b), 32'd1);
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        repeat (14) step;
        check("to_early_ack", 32'(acks_b), 32'd0);
        check("to_early_pulse", 32'(timeout_b), 32'd0);
        step;
        check("to_ack", 32'(acks_b), 32'b010);
        check("to_rdata", 32'(rom2_rdata_b), 32'hFF);
        check("to_pulse", 32'(timeout_b), 32'd1);
        check("to_mem_req", 32'(mem_req_b), 32'd0);
        check("to_a_quiet", 32'(timeout_a), 32'd0);
        rom2_req = 1'b0;
        step;
        check("to_pulse_end", 32'(timeout_b), 32'd0);
        check("to_ack_end", 32'(acks_b), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h3C;
        step;
        mem_rvalid = 1'b0;
        step;
        check("to_stray", {8'h0, rom1_rdata_b, rom2_rdata_b, dsk_rdata_b}, 32'h00FF00);

        // Address wrap: default base on a, 22'h380000 on b
        do_reset;
        dsk_addr = 20'hFFFFF;
        dsk_req  = 1'b1;
        transact("wrap", 22'h2FFFFF, 8'h5A, 0);
        check("wrap_b_addr", 32'(mem_addr_b), 32'h07FFFF);
        check("wrap_ack", 32'(acks_a), 32'b100);
        check("wrap_rdata", 32'(dsk_rdata_a), 32'h5A);
        dsk_req = 1'b0;

        // Grant held off for five cycles
        rom1_addr = 13'h0ABC;
        rom1_req  = 1'b1;
        transact("gdly", 22'h000ABC, 8'hC3, 5);
        check("gdly_ack", 32'(acks_a), 32'b001);
        check("gdly_rdata", 32'(rom1_rdata_a), 32'hC3);
        check("gdly_timeout", {31'h0, timeout_a | timeout_b}, 32'd0);
        rom1_req = 1'b0;

        // Reset while in WAIT, then priority back at ROM1
        rom2_addr = 20'h00010;
        rom2_req  = 1'b1;
        for (int n = 0; n < 20 && !mem_req_a; n++) step;
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        reset_n = 1'b0;
        step;
        check("rw_mem_req", 32'(mem_req_a), 32'd0);
        check("rw_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rw_acks", 32'(acks_a), 32'd0);
        check("rw_rdata", {8'h0, rom1_rdata_a, rom2_rdata_a, dsk_rdata_a}, 32'd0);
        reset_n    = 1'b1;
        rom2_req   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h77;
        step;
        mem_rvalid = 1'b0;
        step;
        check("rw_stray_rdata", {8'h0, rom1_rdata_a, rom2_rdata_a, dsk_rdata_a}, 32'd0);
        check("rw_stray_acks", 32'(acks_a), 32'd0);
        rom1_addr = 13'h0001;
        rom1_req  = 1'b1;
        rom2_req  = 1'b1;
        transact("post1", 22'h000001, 8'h66, 0);
        check("post1_ack", 32'(acks_a), 32'b001);
        rom1_req = 1'b0;
        transact("post2", 22'h100010, 8'h99, 0);
        check("post2_ack", 32'(acks_a), 32'b010);
        check("post2_rdata", 32'(rom2_rdata_a), 32'h99);
        rom2_req = 1'b0;
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/orion_rom_arbiter.md
Name: orion_rom_arbiter

Overview:
Shares one external byte-wide read memory (SDRAM/flash bridge) between the three ROM requesters of the Orion-Pro core: ROM1 (8 KiB), ROM2 (1 MiB) and ROM-disk (1 MiB).
Maps each requester's local address into a region of the physical memory and arbitrates round-robin. Runs one read at a time with a req/gnt/rvalid handshake and a timeout guard.
Sits between orion_pro_top ROM ports and the memory bridge.

Parameters:
MEM_AW, 22, physical memory address width
ROM1_BASE, 22'h000000, physical base of ROM1 region
ROM2_BASE, 22'h100000, physical base of ROM2 region
DSK_BASE, 22'h200000, physical base of ROM-disk region
TIMEOUT, 1023, max cycles from ISSUE entry to rvalid before forced completion

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  reset, synchronous, active-low
i_rom1_req  in  1  ROM1 read request, level, held until ack
i_rom1_addr  in  13  ROM1 byte address, stable while req
o_rom1_rdata  out  8  ROM1 read data, valid with ack, held until next ROM1 ack
o_rom1_ack  out  1  one-cycle completion pulse
i_rom2_req / i_rom2_addr[20] / o_rom2_rdata[8] / o_rom2_ack  same semantics, ROM2
i_dsk_req / i_dsk_addr[20] / o_dsk_rdata[8] / o_dsk_ack  same semantics, ROM-disk
o_mem_req  out  1  memory read request, held until i_mem_gnt
o_mem_addr  out  MEM_AW  physical address, stable while o_mem_req
i_mem_gnt  in  1  memory accepted request this cycle
i_mem_rvalid  in  1  read data valid, one cycle
i_mem_rdata  in  8  read data
o_timeout  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset (i_reset_n=0 at rising edge): FSM to IDLE. o_mem_req=0, o_mem_addr=0, all acks=0, all rdata=8'h00, o_timeout=0, timeout counter=0. RR pointer last=DSK, so ROM1 has top priority. Reset applies in any state; an in-flight read is abandoned.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, pick a winner by round-robin starting at last+1 mod 3. Latch the winner index and o_mem_addr = BASE[w] + zero-extended addr, truncated mod 2^MEM_AW (wrap, no error). Set o_mem_req=1 and go to ISSUE. No req: stay in IDLE.
- ISSUE: hold o_mem_req and o_mem_addr. On i_mem_gnt, drop o_mem_req next edge and go to WAIT. rvalid in the same cycle as gnt is treated as completion and goes straight to RESP.
- WAIT: on i_mem_rvalid, latch i_mem_rdata into the winner's rdata register and go to RESP.
- RESP: winner ack=1 for exactly this cycle; last=winner; next state IDLE.
- Requester contract: a registered requester clears req on the edge where it sees ack=1. IDLE therefore never re-samples a completed request. A req still high in IDLE is a new read.
- Latency with gnt and rvalid in the cycle after each state entry: req seen in IDLE at cycle 0 → o_mem_req at cycle 1 → ack at cycle 4.
- Timeout: counter clears on ISSUE entry and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT: o_mem_req=0, winner rdata=8'hFF, go to RESP, pulse o_timeout together with the ack.
- Simultaneous rvalid and timeout expiry: rvalid wins and o_timeout stays 0.
- i_mem_rvalid or i_mem_gnt outside ISSUE/WAIT: ignored.
- Non-winner rdata registers never change.
- Only one transaction is outstanding; there is no pipelining.

Decomposition:
- Package orion_rom_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - requester index enum (RQ_ROM1=0, RQ_ROM2=1, RQ_DSK=2)
  - NUM_RQ=3
  - rr_next function or constant table
- One sub-module: orion_rr_arbiter3, a combinational 3-way round-robin picker. Inputs: req vector and last index. Outputs: valid and winner index.
- FSM, address mapping and timeout counter stay in the top block.

Test Plan:
- ROM1 addr 13'h0123; gnt 1 cycle after o_mem_req; rvalid 8'hA5 next cycle → o_mem_addr=22'h000123, o_rom1_ack single pulse at cycle 4, o_rom1_rdata=8'hA5 held afterwards, o_timeout=0.
- After reset, all three reqs high together with immediate memory → grants ROM1, ROM2, DSK in order. A ROM1 re-request while ROM2 stays high → ROM2 served before ROM1. Addresses are 0x000000+a1, 0x100000+a2, 0x200000+a3.
- TIMEOUT=16, gnt given, no rvalid → at the 16th cycle after ISSUE entry: ack with rdata=8'hFF, o_timeout pulse. A later stray rvalid 8'h3C does not change any rdata.
- gnt held low for 5 cycles → o_mem_req=1 and o_mem_addr stable throughout. Timeout does not fire if gnt and rvalid arrive within TIMEOUT.
- Wrap: DSK_BASE=22'h380000, dsk addr 20'hFFFFF → o_mem_addr=22'h07FFFF.
- Wrap, default DSK_BASE: dsk addr 20'hFFFFF → o_mem_addr=22'h2FFFFF.
- Reset asserted in WAIT → next edge: o_mem_req=0, all acks=0, all rdata=0. Stray rvalid after reset is ignored. A subsequent ROM2 request completes normally with ROM1 priority restored.
